// File: rtl/result_word_collector.sv
// Result word collector: validates and decodes 16-bit tagged result words,
// buffers legal words in a FIFO, presents decoded head fields on a
// valid/ready port and keeps saturating per-kind, drop and illegal counters.
module result_word_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [4:0]               out_hi,
  output logic [8:0]               out_lo,
  output logic                     out_flag,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cnt_a,
  output logic [CNT_W-1:0]         cnt_b,
  output logic [CNT_W-1:0]         cnt_c,
  output logic [CNT_W-1:0]         cnt_drop,
  output logic [CNT_W-1:0]         cnt_illegal
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] TAG_A = 2'b11;
  localparam logic [1:0] TAG_B = 2'b01;
  localparam logic [1:0] TAG_C = 2'b00;

  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [15:0]    head;
  logic           legal;
  logic           full;
  logic           push;
  logic           pop;
  logic           ill_evt;
  logic           drop_evt;

  // Classify the incoming word: tag 2'b10 and nonzero reserved fields are illegal.
  always_comb begin
    legal = 1'b0;
    case (in_data[15:14])
      TAG_A:   legal = (in_data[8:4] == 5'd0);
      TAG_B:   legal = 1'b1;
      TAG_C:   legal = (in_data[13:9] == 5'd0);
      default: legal = 1'b0;
    endcase
  end

  // Full is judged on the registered level, so a same-cycle pop never frees room.
  always_comb begin
    full      = (level == LW'(DEPTH));
    out_valid = (level != '0);
    pop       = out_valid & out_ready;
    ill_evt   = in_valid & ~legal;
    drop_evt  = in_valid & legal & full;
    push      = in_valid & legal & ~full;
  end

  // Storage array holds raw words; no reset needed since level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level is an explicit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating statistics: each counter holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a       <= '0;
      cnt_b       <= '0;
      cnt_c       <= '0;
      cnt_drop    <= '0;
      cnt_illegal <= '0;
    end else begin
      if (push && in_data[15:14] == TAG_A && cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
      if (push && in_data[15:14] == TAG_B && cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
      if (push && in_data[15:14] == TAG_C && cnt_c != '1) cnt_c <= cnt_c + CNT_W'(1);
      if (drop_evt && cnt_drop != '1)    cnt_drop    <= cnt_drop + CNT_W'(1);
      if (ill_evt && cnt_illegal != '1)  cnt_illegal <= cnt_illegal + CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];

  // Decode the head entry; all fields read zero while the FIFO is empty.
  always_comb begin
    out_kind = 2'b00;
    out_hi   = 5'd0;
    out_lo   = 9'd0;
    out_flag = 1'b0;
    if (out_valid) begin
      out_kind = head[15:14];
      case (head[15:14])
        TAG_A: begin
          out_hi = head[13:9];
          out_lo = {5'd0, head[3:0]};
        end
        TAG_B: begin
          out_hi   = head[13:9];
          out_flag = head[8];
          out_lo   = {1'b0, head[7:0]};
        end
        default: begin
          out_lo = head[8:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_word_collector.sv
// Self-checking bench for result_word_collector: directed table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_result_word_collector;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;

  logic        o_valid, s_valid;
  logic [1:0]  o_kind, s_kind;
  logic [4:0]  o_hi, s_hi;
  logic [8:0]  o_lo, s_lo;
  logic        o_flag, s_flag;
  logic [3:0]  o_level, s_level;
  logic [15:0] o_a, o_b, o_c, o_drop, o_ill;
  logic [3:0]  s_a, s_b, s_c, s_drop, s_ill;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] q[$];
  int ca, cb, cc, cd, ci;

  always #5 clk = ~clk;

  result_word_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(o_valid), .out_ready(out_ready), .out_kind(o_kind), .out_hi(o_hi),
    .out_lo(o_lo), .out_flag(o_flag), .level(o_level), .cnt_a(o_a), .cnt_b(o_b),
    .cnt_c(o_c), .cnt_drop(o_drop), .cnt_illegal(o_ill)
  );

  result_word_collector #(.DEPTH(DEPTH), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(s_valid), .out_ready(out_ready), .out_kind(s_kind), .out_hi(s_hi),
    .out_lo(s_lo), .out_flag(s_flag), .level(s_level), .cnt_a(s_a), .cnt_b(s_b),
    .cnt_c(s_c), .cnt_drop(s_drop), .cnt_illegal(s_ill)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [15:0] w);
    if (w[15:14] == 2'b11) return w[8:4] == 0;
    if (w[15:14] == 2'b01) return 1'b1;
    if (w[15:14] == 2'b00) return w[13:9] == 0;
    return 1'b0;
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_clear();
    q.delete();
    ca = 0; cb = 0; cc = 0; cd = 0; ci = 0;
  endtask

  task automatic check_all();
    logic [15:0] w;
    logic [1:0]  ek;
    logic [4:0]  eh;
    logic [8:0]  el;
    logic        ef;
    ek = 0; eh = 0; el = 0; ef = 0;
    if (q.size() > 0) begin
      w  = q[0];
      ek = w[15:14];
      if (ek == 2'b11) begin eh = w[13:9]; el = {5'd0, w[3:0]}; end
      else if (ek == 2'b01) begin eh = w[13:9]; el = {1'b0, w[7:0]}; ef = w[8]; end
      else el = w[8:0];
    end
    chk("out_valid", o_valid, q.size() > 0);
    chk("out_kind", o_kind, ek);
    chk("out_hi", o_hi, eh);
    chk("out_lo", o_lo, el);
    chk("out_flag", o_flag, ef);
    chk("level", o_level, q.size());
    chk("cnt_a", o_a, sat(ca, 65535));
    chk("cnt_b", o_b, sat(cb, 65535));
    chk("cnt_c", o_c, sat(cc, 65535));
    chk("cnt_drop", o_drop, sat(cd, 65535));
    chk("cnt_illegal", o_ill, sat(ci, 65535));
    chk("s_level", s_level, q.size());
    chk("s_lo", s_lo, el);
    chk("s_cnt_a", s_a, sat(ca, 15));
    chk("s_cnt_b", s_b, sat(cb, 15));
    chk("s_cnt_c", s_c, sat(cc, 15));
    chk("s_cnt_drop", s_drop, sat(cd, 15));
    chk("s_cnt_illegal", s_ill, sat(ci, 15));
  endtask

  // One clock: drive at negedge, advance the model, sample #1 after posedge.
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    bit pop, acc;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r;
    pop = (q.size() > 0) && r;
    acc = 0;
    if (v && !legal(d)) ci++;
    else if (v) begin
      if (q.size() == DEPTH) cd++;
      else acc = 1;
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(d);
      if (d[15:14] == 2'b11) ca++;
      else if (d[15:14] == 2'b01) cb++;
      else cc++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #2 rst = 1;
    #1 model_clear();
    check_all();
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 4))
      0: w = {2'b11, w[13:9], 5'd0, w[3:0]};
      1: w = {2'b01, w[13:0]};
      2: w = {7'd0, w[8:0]};
      3: w = {2'b10, w[13:0]};
      default: ;
    endcase
    return w;
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        ev;
    logic [1:0]  ek;
    logic [4:0]  eh;
    logic [8:0]  el;
    logic        ef;
    logic [3:0]  elv;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 16'hC60A, 1, 1, 2'b11, 5'h03, 9'h00A, 0, 1};
    tbl[1] = '{1, 16'h7F5A, 1, 1, 2'b01, 5'h1F, 9'h05A, 1, 1};
    tbl[2] = '{1, 16'h01FF, 1, 1, 2'b00, 5'h00, 9'h1FF, 0, 1};
    tbl[3] = '{0, 16'h0000, 1, 0, 2'b00, 5'h00, 9'h000, 0, 0};
    tbl[4] = '{1, 16'h8000, 1, 0, 2'b00, 5'h00, 9'h000, 0, 0};
    tbl[5] = '{1, 16'hC610, 1, 0, 2'b00, 5'h00, 9'h000, 0, 0};

    model_clear();
    #1 check_all();
    @(negedge clk);
    rst = 0;

    // Directed decode and illegal-word table
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_valid", o_valid, tbl[i].ev);
      chk("tbl_kind", o_kind, tbl[i].ek);
      chk("tbl_hi", o_hi, tbl[i].eh);
      chk("tbl_lo", o_lo, tbl[i].el);
      chk("tbl_flag", o_flag, tbl[i].ef);
      chk("tbl_level", o_level, tbl[i].elv);
    end
    chk("tbl_cnt_a", o_a, 1);
    chk("tbl_cnt_b", o_b, 1);
    chk("tbl_cnt_c", o_c, 1);
    chk("tbl_cnt_illegal", o_ill, 2);

    // Asynchronous reset mid-stream with three words buffered
    for (int i = 0; i < 3; i++) step(1, 16'h0100 + 16'(i), 0);
    chk("pre_reset_level", o_level, 3);
    do_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_cnt_c", o_c, 0);
    chk("rst_lo", o_lo, 0);

    // Overflow: ten pushes into eight entries, then drain in order
    for (int i = 1; i <= 10; i++) step(1, 16'(i), 0);
    chk("ovf_level", o_level, 8);
    chk("ovf_drop", o_drop, 2);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_lo", o_lo, i);
      step(0, 0, 1);
    end
    chk("drain_empty", o_valid, 0);

    // Push+pop at level 3, then at full
    for (int i = 0; i < 3; i++) step(1, 16'h0011 + 16'(i), 0);
    step(1, 16'h0014, 1);
    chk("cc_level3", o_level, 3);
    chk("cc_head", o_lo, 9'h012);
    for (int i = 0; i < 5; i++) step(1, 16'h0015 + 16'(i), 0);
    chk("cc_full", o_level, 8);
    step(1, 16'h0055, 1);
    chk("cc_full_level", o_level, 7);
    chk("cc_full_drop", o_drop, 3);
    for (int i = 0; i < 7; i++) begin
      chk("cc_order", o_lo, 9'h013 + 9'(i));
      step(0, 0, 1);
    end

    // Randomized traffic, slow then fast reader
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) == 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0);

    // Saturation on the 4-bit counter instance
    do_reset();
    for (int i = 0; i < 20; i++) step(1, {7'd0, 9'($urandom)}, 1);
    chk("sat_cnt_c_4b", s_c, 15);
    chk("sat_cnt_c_16b", o_c, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_word_collector.md
Name: result_word_collector

Overview:
- Downstream consumer of the 16-bit result word produced each cycle by the pipelined state-update stage.
- Validates and decodes the tagged word format, buffers legal words in a FIFO, and presents decoded fields on a valid/ready interface to the host-side reader.
- Keeps saturating statistics for each word kind, for dropped words and for illegal words.

Parameters:
- DEPTH, 8, FIFO entries; a power of two, at least 2.
- CNT_W, 16, width of every statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data carries a word this cycle
- in_data  in  16  tagged result word
- out_valid  out  1  FIFO head available
- out_ready  in  1  reader accepts the head this cycle
- out_kind  out  2  tag of head word (2'b11 A, 2'b01 B, 2'b00 C)
- out_hi  out  5  decoded high field
- out_lo  out  9  decoded low field
- out_flag  out  1  decoded flag bit
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- cnt_a, cnt_b, cnt_c  out  CNT_W  accepted words per kind
- cnt_drop  out  CNT_W  legal words lost because the FIFO was full
- cnt_illegal  out  CNT_W  malformed words rejected

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset: FIFO empties (level=0, out_valid=0). All counters go to 0. out_kind, out_hi, out_lo and out_flag read 0 while empty. Reset asserted mid-operation discards all buffered words immediately. Operation resumes on the first rising edge after rst deasserts.
- Word format and legality:
  - Kind A, [15:14]=2'b11: hi=[13:9], [8:4] reserved and must be zero, lo={5'b0,[3:0]}, flag=0.
  - Kind B, [15:14]=2'b01: hi=[13:9], flag=[8], lo={1'b0,[7:0]}.
  - Kind C, [15:14]=2'b00: [13:9] reserved and must be zero, hi=0, lo=[8:0], flag=0.
  - Tag 2'b10, or a nonzero reserved field, is illegal.
- Push rules:
  - Push attempt = in_valid=1 with a legal word.
  - Illegal word with in_valid=1: not stored; cnt_illegal increments. Illegal takes priority over full, so an illegal word arriving while full counts only as illegal.
  - Full is evaluated on the registered level at the start of the cycle. A push attempt while level==DEPTH is dropped and cnt_drop increments, even if a pop happens the same cycle.
  - Accepted push: raw word written at the clock edge, and the kind counter increments.
- Latency: a word accepted at edge t drives out_valid=1 from edge t onward, i.e. visible in the following cycle when the FIFO was empty. There is no combinational in-to-out bypass.
- Pop: occurs when out_valid=1 and out_ready=1; the head advances at the edge. out_ready is ignored while empty.
- Output fields are decoded combinationally from the registered head entry. Order is strict FIFO.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, both take effect.
- Simultaneous push and pop at level==DEPTH: push dropped, level becomes DEPTH-1.
- Read and write pointers wrap modulo DEPTH. level is maintained as an explicit counter.
- All counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset: assert rst asynchronously mid-stream with 3 words buffered -> out_valid=0, level=0, all counters 0 before the next clk edge; output fields 0.
- Decode: push 16'hC60A, 16'h7F5A, 16'h01FF with out_ready=1:
  - cycle after each push, out_valid=1;
  - head decodes to (kind 11, hi 03, lo 00A, flag 0), then (01, 1F, 05A, 1), then (00, 00, 1FF, 0);
  - cnt_a=cnt_b=cnt_c=1.
- Illegal: push 16'h8000 and 16'hC610 -> nothing stored, level=0, cnt_illegal=2, kind counters unchanged.
- Full/overflow (DEPTH=8): out_ready=0, push 10 legal words 16'h0001..16'h000A -> level=8, cnt_drop=2; draining yields lo=001..008 in order.
- Concurrency:
  - At level=3, push and pop in the same cycle -> level stays 3, and order is preserved.
  - At level=8, push 16'h0055 and pop in the same cycle -> 16'h0055 dropped, cnt_drop+1, level=7.
- Saturation (CNT_W=4): push 20 kind-C words while draining -> cnt_c holds 15.
